// File: rtl/fifo_drain_packer.sv
// fifo_drain_packer
// Drains elements from the head of an upstream FIFO and packs COUNT of them
// into one output word. Slot 0 holds the first element popped. A flush
// emits a partially filled word, with unfilled slots reading zero. The
// upstream FIFO gives priority to its own push, so an element counts as
// taken only on a cycle where fifoPop is high and no effective push occurs.
//
// Handshake: outValid/outData/outCount are registered and hold steady while
// outValid=1 && outReady=0. A word transfers on any rising edge where
// outValid && outReady. outReady has no effect while outValid=0.
//
// Ports
//   clock, reset_n   rising-edge clock; asynchronous active-low reset
//   fifoData         upstream FIFO head element (valid when fifoEmpty=0)
//   fifoEmpty        upstream FIFO empty flag
//   fifoFull         upstream FIFO full flag
//   fifoPush         upstream FIFO push input, observed in the same cycle
//   fifoPop          pop request to the upstream FIFO (combinational)
//   flush            emit the current partial word
//   outData          packed word (registered)
//   outValid         outData/outCount hold a word (registered)
//   outReady         downstream accepts the word
//   outCount         number of valid elements in outData (registered)
//   wordCount        words delivered since reset, wraps 255->0
//   dbg_state        current FSM state (0=FILL, 1=HOLD)
module fifo_drain_packer #(
  parameter int MSBD  = 3,
  parameter int COUNT = 4,
  parameter int MSBW  = (MSBD + 1) * COUNT - 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [MSBD:0]   fifoData,
  input  logic            fifoEmpty,
  input  logic            fifoFull,
  input  logic            fifoPush,
  output logic            fifoPop,
  input  logic            flush,
  output logic [MSBW:0]   outData,
  output logic            outValid,
  input  logic            outReady,
  output logic [2:0]      outCount,
  output logic [7:0]      wordCount,
  output logic            dbg_state
);

  localparam int EW = MSBD + 1;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [MSBW:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    wc_q, wc_d;

  logic          accept;
  logic          last_slot;

  // Gating with reset_n keeps the upstream FIFO untouched while reset is
  // held, even though the state register is already forced to FILL.
  assign fifoPop   = reset_n & (state_q == ST_FILL) & ~fifoEmpty;
  // The upstream FIFO ignores pop on a cycle where its push takes effect.
  assign accept    = fifoPop & ~(fifoPush & ~fifoFull);
  assign last_slot = (idx_q == 3'(COUNT - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    wc_d    = wc_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          for (int k = 0; k < COUNT; k++) begin
            if (idx_q == 3'(k)) begin
              data_d[k*EW +: EW] = fifoData;
            end
          end
          if (last_slot || flush) begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
            cnt_d   = idx_q + 3'd1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (flush && (idx_q != 3'd0)) begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
          cnt_d   = idx_q;
        end
      end
      ST_HOLD: begin
        if (valid_q && outReady) begin
          state_d = ST_FILL;
          idx_d   = 3'd0;
          // Clearing here guarantees zeros in the unfilled slots of the
          // next partial word.
          data_d  = '0;
          valid_d = 1'b0;
          wc_d    = wc_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FILL;
      idx_q   <= 3'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 3'd0;
      wc_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      wc_q    <= wc_d;
    end
  end

  assign outData   = data_q;
  assign outValid  = valid_q;
  assign outCount  = cnt_q;
  assign wordCount = wc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Bench for fifo_drain_packer. The upstream FIFO is a queue inside the bench,
// where push wins over pop. The reference model works from the sequence of
// elements the FIFO hands out. It groups them COUNT at a time, or ends a
// group early on flush, and pushes each expected word into exp_q. A separate
// monitor pops exp_q on every outValid && outReady transfer.
module tb_fifo_drain_packer;

  localparam int MSBD  = 3;
  localparam int COUNT = 4;
  localparam int EW    = MSBD + 1;
  localparam int DW    = EW * COUNT;
  localparam int W     = 3 + DW;
  localparam int DEPTH = 8;

  logic          clock;
  logic          reset_n;
  logic [EW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  logic          flush;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_count;
  logic [7:0]    word_count;
  logic          dbg_state;

  fifo_drain_packer #(.MSBD(MSBD), .COUNT(COUNT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .fifoData  (fifo_data),
    .fifoEmpty (fifo_empty),
    .fifoFull  (fifo_full),
    .fifoPush  (fifo_push),
    .fifoPop   (fifo_pop),
    .flush     (flush),
    .outData   (out_data),
    .outValid  (out_valid),
    .outReady  (out_ready),
    .outCount  (out_count),
    .wordCount (word_count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- bench state ----------------
  logic [EW-1:0] fifo_q[$];
  logic [EW-1:0] m_cur[$];
  logic          m_holding;
  logic [W-1:0]  exp_q[$];
  logic [7:0]    exp_wc;
  logic [EW-1:0] push_val;
  logic [EW-1:0] seq;
  logic [DW-1:0] last_data;
  logic [2:0]    last_count;
  int            n_cmp;
  int            n_fail;
  int            total_words;
  int            wsr;
  logic          wrap_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_full  = (fifo_q.size() == DEPTH);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endfunction

  function automatic void clear_model();
    m_cur.delete();
    exp_q.delete();
    m_holding = 1'b0;
    exp_wc    = 8'd0;
    wsr       = 0;
    wrap_done = 1'b0;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Inputs set by the caller are stable from here through the next rising
  // edge. The model runs on the falling edge, and the FIFO queue updates
  // just after the rising edge.
  task automatic step();
    logic          push_eff;
    logic          pop_eff;
    logic          release_w;
    logic [DW-1:0] w;
    @(negedge clock);
    push_eff  = fifo_push && (fifo_q.size() < DEPTH);
    pop_eff   = fifo_pop && !push_eff && (fifo_q.size() > 0);
    check("fifo_pop", 32'(fifo_pop), 32'(!m_holding && fifo_q.size() > 0));
    check("out_valid", 32'(out_valid), 32'(m_holding));
    check("dbg_state", 32'(dbg_state), 32'(m_holding));
    release_w = m_holding && out_valid && out_ready;
    if (pop_eff && !m_holding) m_cur.push_back(fifo_q[0]);
    if (!m_holding && (m_cur.size() == COUNT || (flush && m_cur.size() > 0))) begin
      w = '0;
      for (int k = 0; k < m_cur.size(); k++) w[k*EW +: EW] = m_cur[k];
      exp_q.push_back({3'(m_cur.size()), w});
      m_cur.delete();
      m_holding = 1'b1;
    end else if (release_w) begin
      m_holding = 1'b0;
    end
    @(posedge clock);
    #1;
    if (push_eff) fifo_q.push_back(push_val);
    else if (pop_eff) void'(fifo_q.pop_front());
    refresh_fifo();
  endtask

  task automatic run_until_words(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (total_words < target && n < budget) begin
      step();
      n++;
    end
    check({name, "_timeout"}, 32'(total_words >= target), 32'd1);
  endtask

  task automatic run_until_drained(input int cur_size, input int budget, input string name);
    int n;
    n = 0;
    while (!(fifo_q.size() == 0 && m_cur.size() == cur_size) && n < budget) begin
      step();
      n++;
    end
    check({name, "_timeout"}, 32'(fifo_q.size() == 0 && m_cur.size() == cur_size), 32'd1);
  endtask

  task automatic push_one(input logic [EW-1:0] v);
    fifo_push = 1'b1;
    push_val  = v;
    step();
    fifo_push = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic          pv;
    logic [DW-1:0] pd;
    logic [2:0]    pc;
    logic [W-1:0]  e;
    pv = 1'b0;
    pd = '0;
    pc = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pv = 1'b0;
        continue;
      end
      check("word_count", 32'(word_count), 32'(exp_wc));
      if (wsr == 256 && !wrap_done) begin
        check("wc_wrap", 32'(word_count), 32'd0);
        wrap_done = 1'b1;
      end
      if (pv) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(pd));
        check("hold_count", 32'(out_count), 32'(pc));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 32'(out_data), 32'(e[DW-1:0]));
          check("word_elems", 32'(out_count), 32'(e[W-1:DW]));
        end
        last_data  = out_data;
        last_count = out_count;
        exp_wc     = exp_wc + 8'd1;
        total_words++;
        wsr++;
        pv = 1'b0;
      end else begin
        pv = out_valid;
        pd = out_data;
        pc = out_count;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    n_cmp       = 0;
    n_fail      = 0;
    total_words = 0;
    seq         = '0;
    push_val    = '0;
    last_data   = '0;
    last_count  = '0;
    fifo_push   = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    reset_n     = 1'b0;
    clear_model();
    // A non-empty FIFO during reset: fifoPop must stay low.
    fifo_q.push_back(4'h9);
    refresh_fifo();
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    check("rst_pop", 32'(fifo_pop), 32'd0);
    fifo_q.delete();
    refresh_fifo();
    @(posedge clock);
    #2;
    reset_n = 1'b1;

    // Four elements, downstream always ready.
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) push_one(4'(v));
    run_until_words(1, 40, "basic");
    check("basic_data", 32'(last_data), 32'h4321);
    check("basic_count", 32'(last_count), 32'd4);
    check("basic_wc", 32'(word_count), 32'd1);

    // Push held for several cycles while the FIFO is not empty: pop is
    // requested but nothing is taken until push drops.
    push_one(4'h7);
    fifo_push = 1'b1;
    for (int v = 8; v <= 10; v++) begin
      push_val = 4'(v);
      step();
      check("stall_pop", 32'(fifo_pop), 32'd1);
    end
    check("stall_nothing_taken", 32'(m_cur.size()), 32'd0);
    fifo_push = 1'b0;
    run_until_words(2, 40, "stall");
    check("stall_data", 32'(last_data), 32'hA987);

    // Back-pressure: a full word held for 10 cycles with data left in FIFO.
    out_ready = 1'b0;
    for (int v = 11; v <= 16; v++) push_one(4'(v));
    begin
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
        step();
        n++;
      end
      check("bp_valid_timeout", 32'(out_valid), 32'd1);
    end
    for (int i = 0; i < 10; i++) step();
    check("bp_occupancy", 32'(fifo_q.size()), 32'd2);
    out_ready = 1'b1;
    run_until_words(3, 20, "bp");
    check("bp_data", 32'(last_data), 32'hEDCB);
    // Leftover F,0 go out as a 2-element flushed word.
    run_until_drained(2, 20, "left");
    flush = 1'b1;
    step();
    flush = 1'b0;
    run_until_words(4, 20, "left");
    check("left_data", 32'(last_data), 32'h000F);
    check("left_count", 32'(last_count), 32'd2);

    // Partial word 5,6 via flush, then a flush with nothing collected.
    push_one(4'h5);
    push_one(4'h6);
    run_until_drained(2, 20, "flush");
    flush = 1'b1;
    step();
    flush = 1'b0;
    run_until_words(5, 20, "flush");
    check("flush_data", 32'(last_data), 32'h0065);
    check("flush_count", 32'(last_count), 32'd2);
    base = total_words;
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("empty_flush_words", 32'(total_words), 32'(base));
    check("empty_flush_exp", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset between edges while a word is held.
    out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) push_one(4'(v));
    begin
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
        step();
        n++;
      end
      check("arst_hold_timeout", 32'(out_valid), 32'd1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_wc", 32'(word_count), 32'd0);
    check("arst_count", 32'(out_count), 32'd0);
    check("arst_pop", 32'(fifo_pop), 32'd0);
    clear_model();
    @(posedge clock);
    #2;
    reset_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      fifo_push = ($urandom_range(0, 99) < 50);
      push_val  = seq;
      if (fifo_push) seq = seq + 4'd1;
      flush     = ($urandom_range(0, 99) < 6);
      out_ready = ($urandom_range(0, 99) < 70);
      step();
    end

    // Keep going until 256 words have been delivered since reset.
    begin
      int n;
      n = 0;
      while (wsr < 260 && n < 8000) begin
        fifo_push = (fifo_q.size() < 3) ? 1'b1 : ($urandom_range(0, 3) == 0);
        push_val  = seq;
        if (fifo_push) seq = seq + 4'd1;
        flush     = ($urandom_range(0, 99) < 3);
        out_ready = ($urandom_range(0, 99) < 90);
        step();
        n++;
      end
      check("wrap_timeout", 32'(wsr >= 260), 32'd1);
      check("wrap_seen", 32'(wrap_done), 32'd1);
    end

    // Drain everything still in flight.
    fifo_push = 1'b0;
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (!(fifo_q.size() == 0 && m_cur.size() == 0 && !m_holding && exp_q.size() == 0)
             && n < 200) begin
        flush = ($urandom_range(0, 1) == 1);
        step();
        n++;
      end
      flush = 1'b0;
      step();
      step();
      check("drain_exp", 32'(exp_q.size()), 32'd0);
      check("drain_cur", 32'(m_cur.size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
